// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control sequencer: states, opcodes,
// ALU control fields and fault codes.
package rv32_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXEC_R    = 4'd6,
      ST_EXEC_I    = 4'd7,
      ST_ALU_WB    = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_HALT      = 4'd10
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_REG  = 2'b00,
      SRCB_FOUR = 2'b01,
      SRCB_IMM  = 2'b10,
      SRCB_ZERO = 2'b11
   } src_b_t;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'b00,
      FAULT_ILLEGAL = 2'b01,
      FAULT_TIMEOUT = 2'b10
   } fault_t;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory wait state; expired flags the
// last cycle before the stall budget is exhausted. TIMEOUT_CYCLES = 0 disables it.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/rv32_multicycle_ctrl_fsm.sv
// Main sequencer of the multicycle RV32 datapath: fetch, decode, execute,
// memory and writeback, with memory-wait timeout and illegal-opcode halt.
module rv32_multicycle_ctrl_fsm
   import rv32_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       PCSource,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic       instr_retired,
   output logic       halted,
   output logic [1:0] fault,
   output logic [3:0] state_dbg
);

   // Memory handshake: MemRead/MemWrite is a request held every cycle of a wait
   // state; mem_ready=1 in that same cycle completes it and the FSM advances.
   state_t state, state_next;
   fault_t fault_q, fault_next;
   logic   legal, in_wait, timer_clr, timer_inc, timer_expired, timed_out;

   assign legal     = is_legal(opcode);
   assign in_wait   = (state == ST_FETCH) || (state == ST_MEM_READ) || (state == ST_MEM_WRITE);
   assign timed_out = in_wait && !mem_ready && timer_expired;
   assign timer_inc = in_wait && !mem_ready;
   assign timer_clr = (state_next != state);

   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr    (timer_clr),
      .inc    (timer_inc),
      .expired(timer_expired)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_FETCH;
         fault_q <= FAULT_NONE;
      end else begin
         state   <= state_next;
         fault_q <= fault_next;
      end
   end

   always_comb begin
      state_next = state;
      fault_next = fault_q;
      case (state)
         ST_FETCH:     if (mem_ready) state_next = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = ST_MEM_ADDR;
               OP_R:         state_next = ST_EXEC_R;
               OP_I:         state_next = ST_EXEC_I;
               OP_BEQ:       state_next = ST_BRANCH;
               default: begin
                  state_next = ST_HALT;
                  fault_next = FAULT_ILLEGAL;
               end
            endcase
         end
         ST_MEM_ADDR:  state_next = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ:  if (mem_ready) state_next = ST_MEM_WB;
         ST_MEM_WRITE: if (mem_ready) state_next = ST_FETCH;
         ST_EXEC_R,
         ST_EXEC_I:    state_next = ST_ALU_WB;
         ST_MEM_WB,
         ST_ALU_WB,
         ST_BRANCH:    state_next = ST_FETCH;
         ST_HALT:      state_next = ST_HALT;
         default:      state_next = ST_FETCH;
      endcase
      // A completing mem_ready always beats the timeout in the same cycle.
      if (timed_out) begin
         state_next = ST_HALT;
         fault_next = FAULT_TIMEOUT;
      end
   end

   always_comb begin
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      IRWrite       = 1'b0;
      PCSource      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_REG;
      ALUOp         = ALU_ADD;
      RegWrite      = 1'b0;
      instr_retired = 1'b0;
      halted        = 1'b0;
      // Gating on resetn keeps every control quiet the moment reset falls.
      if (resetn) begin
         case (state)
            ST_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = mem_ready;
            end
            ST_DECODE: begin
               ALUSrcB  = SRCB_IMM;
               PCSource = 1'b1;
               PCWrite  = legal;
            end
            ST_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            ST_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            ST_MEM_WB: begin
               RegWrite      = 1'b1;
               MemtoReg      = 1'b1;
               instr_retired = 1'b1;
            end
            ST_MEM_WRITE: begin
               MemWrite      = 1'b1;
               IorD          = 1'b1;
               instr_retired = mem_ready;
            end
            ST_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALU_FUNCT;
            end
            ST_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALU_FUNCT;
            end
            ST_ALU_WB: begin
               RegWrite      = 1'b1;
               instr_retired = 1'b1;
            end
            ST_BRANCH: begin
               ALUSrcA       = 1'b1;
               ALUOp         = ALU_SUB;
               PCWriteCond   = 1'b1;
               PCSource      = 1'b1;
               instr_retired = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign fault     = resetn ? fault_q : FAULT_NONE;
   assign state_dbg = resetn ? state : 4'd0;

endmodule

// File: tb/tb_rv32_multicycle_ctrl_fsm.sv
// Self-checking bench for rv32_multicycle_ctrl_fsm: directed vector table,
// hand-written corner sequences and a randomized run against an instruction-level model.
module tb_rv32_multicycle_ctrl_fsm;
   import rv32_ctrl_pkg::*;

   localparam int TO = 4;
   localparam int CW = 22;
   localparam logic [6:0] OP_ILL = 7'b1111111;

   typedef struct packed {
      logic       pcw, pcwc, iord, mr, mw, m2r, irw, pcs, asa;
      logic [1:0] asb, aop;
      logic       rw, ret, hlt;
      logic [1:0] flt;
      logic [3:0] st;
   } ctrl_t;

   typedef struct {
      logic [6:0] op;
      logic       rdy;
      ctrl_t      exp;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic       PCSource, ALUSrcA, RegWrite, instr_retired, halted;
   logic [1:0] ALUSrcB, ALUOp, fault;
   logic [3:0] state_dbg;
   ctrl_t      act;

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_q[$];
   vec_t vecs[$];

   rv32_multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
      .instr_retired(instr_retired), .halted(halted), .fault(fault), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
                 ALUSrcA, ALUSrcB, ALUOp, RegWrite, instr_retired, halted, fault, state_dbg};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input ctrl_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (state got %0d required %0d)",
                  name, act, exp, act.st, exp.st);
      end
   endtask

   // ---------------- driver tasks (called just after a falling edge) ----------------
   task automatic do_reset();
      resetn    = 1'b0;
      mem_ready = 1'b0;
      #2;
      check("reset_outputs", '0);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic drive_check(input logic [6:0] op, input logic rdy, input ctrl_t exp,
                              input string name);
      opcode    = op;
      mem_ready = rdy;
      #2;
      check(name, exp);
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   function automatic bit legal_op(input logic [6:0] op);
      return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};
   endfunction

   // Control word the datapath needs in each phase of an instruction.
   function automatic ctrl_t model_out(input state_t s, input logic rdy, input logic [6:0] op,
                                       input logic [1:0] flt);
      ctrl_t e = '0;
      e.st = s;
      case (s)
         ST_FETCH:     begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; end
         ST_DECODE:    begin e.asb = 2'b10; e.pcs = 1; e.pcw = legal_op(op); end
         ST_MEM_ADDR:  begin e.asa = 1; e.asb = 2'b10; end
         ST_MEM_READ:  begin e.mr = 1; e.iord = 1; end
         ST_MEM_WB:    begin e.rw = 1; e.m2r = 1; e.ret = 1; end
         ST_MEM_WRITE: begin e.mw = 1; e.iord = 1; e.ret = rdy; end
         ST_EXEC_R:    begin e.asa = 1; e.aop = 2'b10; end
         ST_EXEC_I:    begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b10; end
         ST_ALU_WB:    begin e.rw = 1; e.ret = 1; end
         ST_BRANCH:    begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 1; e.ret = 1; end
         ST_HALT:      begin e.hlt = 1; e.flt = flt; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic run_random(input int n);
      for (int k = 0; k < n; k++) begin
         logic [6:0] op;
         int         p;
         int         r;
         state_t     steps[$];
         logic [1:0] flt;
         bit         stop;
         r     = $urandom_range(0, 15);
         p     = $urandom_range(40, 95);
         flt   = 2'b00;
         stop  = 0;
         steps = '{ST_FETCH, ST_DECODE};
         case (r)
            0, 1, 2:    begin op = OP_R;   steps.push_back(ST_EXEC_R); steps.push_back(ST_ALU_WB); end
            3, 4, 5:    begin op = OP_I;   steps.push_back(ST_EXEC_I); steps.push_back(ST_ALU_WB); end
            6, 7, 8:    begin op = OP_LW;  steps.push_back(ST_MEM_ADDR); steps.push_back(ST_MEM_READ);
                                           steps.push_back(ST_MEM_WB); end
            9, 10, 11:  begin op = OP_SW;  steps.push_back(ST_MEM_ADDR); steps.push_back(ST_MEM_WRITE); end
            12, 13, 14: begin op = OP_BEQ; steps.push_back(ST_BRANCH); end
            default: begin
               op = OP_ILL;
               do op = 7'($urandom_range(0, 127)); while (legal_op(op));
            end
         endcase
         for (int i = 0; i < steps.size() && !stop; i++) begin
            int   waits;
            logic rdy;
            bit   waiting;
            waits   = 0;
            waiting = steps[i] inside {ST_FETCH, ST_MEM_READ, ST_MEM_WRITE};
            forever begin
               rdy       = ($urandom_range(0, 99) < p);
               opcode    = (steps[i] == ST_FETCH) ? 7'($urandom_range(0, 127)) : op;
               mem_ready = rdy;
               exp_q.push_back(model_out(steps[i], rdy, op, 2'b00));
               #2;
               check($sformatf("rand_%0d_%s", k, steps[i].name()), ctrl_t'(exp_q.pop_front()));
               @(negedge clk);
               if (!waiting || rdy) break;
               waits++;
               if (waits == TO) begin
                  stop = 1;
                  flt  = 2'b10;
                  break;
               end
            end
            if (steps[i] == ST_DECODE && !legal_op(op)) begin
               stop = 1;
               flt  = 2'b01;
            end
         end
         if (stop) begin
            for (int j = 0; j < 3; j++) begin
               opcode    = 7'($urandom_range(0, 127));
               mem_ready = 1'($urandom_range(0, 1));
               exp_q.push_back(model_out(ST_HALT, mem_ready, opcode, flt));
               #2;
               check($sformatf("rand_%0d_halt", k), ctrl_t'(exp_q.pop_front()));
               @(negedge clk);
            end
            do_reset();
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      ctrl_t fetch_ok, fetch_wait, dec_ok, e;

      fetch_ok = '0; fetch_ok.st = ST_FETCH; fetch_ok.mr = 1; fetch_ok.asb = 2'b01; fetch_ok.irw = 1;
      fetch_wait = fetch_ok; fetch_wait.irw = 0;
      dec_ok = '0; dec_ok.st = ST_DECODE; dec_ok.asb = 2'b10; dec_ok.pcs = 1; dec_ok.pcw = 1;

      // addi: FETCH, DECODE, EXEC_I, ALU_WB
      vecs.push_back('{OP_I, 1'b1, fetch_ok, "addi_fetch"});
      vecs.push_back('{OP_I, 1'b1, dec_ok, "addi_decode"});
      e = '0; e.st = ST_EXEC_I; e.asa = 1; e.asb = 2'b10; e.aop = 2'b10;
      vecs.push_back('{OP_I, 1'b1, e, "addi_exec"});
      e = '0; e.st = ST_ALU_WB; e.rw = 1; e.ret = 1;
      vecs.push_back('{OP_I, 1'b1, e, "addi_wb"});
      // lw with three stalled read cycles: 8 cycles total
      vecs.push_back('{OP_LW, 1'b1, fetch_ok, "lw_fetch"});
      vecs.push_back('{OP_LW, 1'b1, dec_ok, "lw_decode"});
      e = '0; e.st = ST_MEM_ADDR; e.asa = 1; e.asb = 2'b10;
      vecs.push_back('{OP_LW, 1'b1, e, "lw_addr"});
      e = '0; e.st = ST_MEM_READ; e.mr = 1; e.iord = 1;
      for (int i = 0; i < 3; i++) vecs.push_back('{OP_LW, 1'b0, e, "lw_read_wait"});
      vecs.push_back('{OP_LW, 1'b1, e, "lw_read_done"});
      e = '0; e.st = ST_MEM_WB; e.rw = 1; e.m2r = 1; e.ret = 1;
      vecs.push_back('{OP_LW, 1'b1, e, "lw_wb"});
      // beq: third cycle branches, fourth is FETCH
      vecs.push_back('{OP_BEQ, 1'b1, fetch_ok, "beq_fetch"});
      vecs.push_back('{OP_BEQ, 1'b1, dec_ok, "beq_decode"});
      e = '0; e.st = ST_BRANCH; e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 1; e.ret = 1;
      vecs.push_back('{OP_BEQ, 1'b0, e, "beq_branch"});
      // sw and R-type
      vecs.push_back('{OP_SW, 1'b1, fetch_ok, "sw_fetch"});
      vecs.push_back('{OP_SW, 1'b1, dec_ok, "sw_decode"});
      e = '0; e.st = ST_MEM_ADDR; e.asa = 1; e.asb = 2'b10;
      vecs.push_back('{OP_SW, 1'b1, e, "sw_addr"});
      e = '0; e.st = ST_MEM_WRITE; e.mw = 1; e.iord = 1; e.ret = 1;
      vecs.push_back('{OP_SW, 1'b1, e, "sw_write"});
      vecs.push_back('{OP_R, 1'b1, fetch_ok, "r_fetch"});
      vecs.push_back('{OP_R, 1'b1, dec_ok, "r_decode"});
      e = '0; e.st = ST_EXEC_R; e.asa = 1; e.aop = 2'b10;
      vecs.push_back('{OP_R, 1'b1, e, "r_exec"});
      e = '0; e.st = ST_ALU_WB; e.rw = 1; e.ret = 1;
      vecs.push_back('{OP_R, 1'b1, e, "r_wb"});
      vecs.push_back('{OP_R, 1'b0, fetch_wait, "r_back_to_fetch"});

      @(negedge clk);
      do_reset();
      foreach (vecs[i]) drive_check(vecs[i].op, vecs[i].rdy, vecs[i].exp, vecs[i].name);

      // Illegal opcode: no PC write in DECODE, then a sticky halt
      do_reset();
      drive_check(OP_ILL, 1'b1, fetch_ok, "ill_fetch");
      e = dec_ok; e.pcw = 0;
      drive_check(OP_ILL, 1'b1, e, "ill_decode");
      e = '0; e.st = ST_HALT; e.hlt = 1; e.flt = 2'b01;
      for (int i = 0; i < 20; i++)
         drive_check(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), e, "ill_halt");

      // Fetch timeout after exactly TO stalled cycles
      do_reset();
      for (int i = 0; i < TO; i++) drive_check(OP_I, 1'b0, fetch_wait, "to_fetch_wait");
      e = '0; e.st = ST_HALT; e.hlt = 1; e.flt = 2'b10;
      drive_check(OP_I, 1'b0, e, "to_halt");
      drive_check(OP_I, 1'b1, e, "to_halt_held");

      // mem_ready in the last allowed cycle wins over the timeout
      do_reset();
      for (int i = 0; i < TO - 1; i++) drive_check(OP_I, 1'b0, fetch_wait, "to_edge_wait");
      drive_check(OP_I, 1'b1, fetch_ok, "to_edge_ready");
      drive_check(OP_I, 1'b1, dec_ok, "to_edge_decode");

      // Reset falling in the middle of a stalled store
      do_reset();
      drive_check(OP_SW, 1'b1, fetch_ok, "rst_sw_fetch");
      drive_check(OP_SW, 1'b1, dec_ok, "rst_sw_decode");
      e = '0; e.st = ST_MEM_ADDR; e.asa = 1; e.asb = 2'b10;
      drive_check(OP_SW, 1'b1, e, "rst_sw_addr");
      opcode    = OP_SW;
      mem_ready = 1'b0;
      #2;
      e = '0; e.st = ST_MEM_WRITE; e.mw = 1; e.iord = 1;
      check("rst_sw_write", e);
      resetn = 1'b0;
      #1;
      check("rst_mid_write_quiet", '0);
      @(negedge clk);
      resetn = 1'b1;
      drive_check(OP_SW, 1'b1, fetch_ok, "rst_after_fetch");

      // Randomized run against the instruction-level model
      do_reset();
      run_random(400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
